// File: rtl/fight_pkg.sv
// Shared definitions for the fight controller.
// Contents:
//   fight_state_t - 6-bit state codes understood by the fight-scene renderer
//   OPT_1..OPT_4  - 4-bit option codes of the 2x2 skill grid
//   skill_dmg()   - damage dealt by each skill option
package fight_pkg;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'd0,
        ST_MENU     = 6'd1,
        ST_CHOOSING = 6'd2,
        ST_ANIM_P1  = 6'd3,   // P1 attack animation
        ST_ANIM_P2  = 6'd4,   // P2 attack animation
        ST_HPRED_P1 = 6'd5,   // P1 losing HP
        ST_HPRED_P2 = 6'd6,   // P2 losing HP
        ST_DONE     = 6'd7
    } fight_state_t;

    localparam logic [3:0] OPT_1 = 4'd1;
    localparam logic [3:0] OPT_2 = 4'd2;
    localparam logic [3:0] OPT_3 = 4'd3;
    localparam logic [3:0] OPT_4 = 4'd4;

    function automatic logic [7:0] skill_dmg(input logic [3:0] opt);
        case (opt)
            OPT_1:   return 8'd10;
            OPT_2:   return 8'd20;
            OPT_3:   return 8'd30;
            OPT_4:   return 8'd40;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/fight_controller_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, stepping every clock.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset, loads SEED
//   q   - current register value
// A zero SEED locks the register at zero, so SEED must be non-zero.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/fight_controller.sv
// Turn-based battle engine feeding the fight-scene renderer.
// P1 picks a skill from a 2x2 grid with one-pulse keys; P2 (CPU) picks a
// skill from the low LFSR bits. Attack animations and HP drain advance on
// the per-frame tick.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   tick               - one pulse per video frame
//   start              - begin a fight from IDLE or DONE
//   key_up/down/left/right/enter - one-pulse key inputs
//   fight_state        - state code (fight_pkg::fight_state_t)
//   option_state       - highlighted option 1..4
//   p1_cur_hp/p2_cur_hp - player HP
//   winner             - 0 none, 1 P1, 2 P2
//   fight_done         - high while in DONE
module fight_controller
    import fight_pkg::*;
#(
    parameter int         HP_MAX     = 200,
    parameter int         ANIM_TICKS = 60,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_enter,
    output logic [5:0] fight_state,
    output logic [3:0] option_state,
    output logic [7:0] p1_cur_hp,
    output logic [7:0] p2_cur_hp,
    output logic [1:0] winner,
    output logic       fight_done
);

    localparam logic [7:0] HP_INIT   = 8'(HP_MAX);
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_TICKS - 1);

    // Decrement that never wraps below zero.
    function automatic logic [7:0] sat_dec(input logic [7:0] v, input logic en);
        return (en && v != 8'd0) ? v - 8'd1 : v;
    endfunction

    fight_state_t state_q, state_d;
    logic [3:0]   opt_q, opt_d;
    logic [7:0]   p1_q, p1_d, p2_q, p2_d;
    logic [7:0]   dmg_q, dmg_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [1:0]   win_q, win_d;
    logic         done_q;

    logic [7:0]   lfsr_q;
    logic         lfsr_unused;
    logic [3:0]   cpu_opt;
    logic [1:0]   idx, idx_n;
    logic [3:0]   opt_moved;
    logic [7:0]   drain_hp, hp_n, dmg_n;
    logic         hit;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the two low bits choose the CPU skill; the rest just feed the shifter.
    assign lfsr_unused = ^lfsr_q[7:2];
    assign cpu_opt     = {2'b00, lfsr_q[1:0]} + 4'd1;

    // Grid move: bit 1 of the zero-based index is the row, bit 0 the column.
    // Priority up > down > left > right; enter is handled by the FSM first.
    always_comb begin
        idx   = 2'(opt_q - 4'd1);
        idx_n = idx;
        if (key_up || key_down)         idx_n = idx ^ 2'b10;
        else if (key_left || key_right) idx_n = idx ^ 2'b01;
        opt_moved = {2'b00, idx_n} + 4'd1;
    end

    // Shared drain step: whichever player is losing HP this state.
    always_comb begin
        drain_hp = (state_q == ST_HPRED_P1) ? p1_q : p2_q;
        hit      = (drain_hp != 8'd0) && (dmg_q != 8'd0);
        hp_n     = sat_dec(drain_hp, hit);
        dmg_n    = sat_dec(dmg_q, hit);
    end

    always_comb begin
        state_d = state_q;
        opt_d   = opt_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        dmg_d   = dmg_q;
        cnt_d   = cnt_q;
        win_d   = win_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_MENU;
                    opt_d   = OPT_1;
                    p1_d    = HP_INIT;
                    p2_d    = HP_INIT;
                    dmg_d   = 8'd0;
                    cnt_d   = 8'd0;
                    win_d   = 2'd0;
                end
            end
            ST_MENU: begin
                if (key_enter) begin
                    state_d = ST_CHOOSING;
                    opt_d   = OPT_1;
                end else begin
                    opt_d = opt_moved;
                end
            end
            ST_CHOOSING: begin
                if (key_enter) begin
                    state_d = ST_ANIM_P1;
                    dmg_d   = skill_dmg(opt_q);
                    cnt_d   = 8'd0;
                end else begin
                    opt_d = opt_moved;
                end
            end
            ST_ANIM_P1, ST_ANIM_P2: begin
                if (tick) begin
                    if (cnt_q >= ANIM_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = (state_q == ST_ANIM_P1) ? ST_HPRED_P2 : ST_HPRED_P1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_HPRED_P2: begin
                if (tick) begin
                    p2_d  = hp_n;
                    dmg_d = dmg_n;
                    // A knockout wins over the end of the attack.
                    if (hp_n == 8'd0) begin
                        state_d = ST_DONE;
                        win_d   = 2'd1;
                    end else if (dmg_n == 8'd0) begin
                        state_d = ST_ANIM_P2;
                        dmg_d   = skill_dmg(cpu_opt);
                        cnt_d   = 8'd0;
                    end
                end
            end
            ST_HPRED_P1: begin
                if (tick) begin
                    p1_d  = hp_n;
                    dmg_d = dmg_n;
                    if (hp_n == 8'd0) begin
                        state_d = ST_DONE;
                        win_d   = 2'd2;
                    end else if (dmg_n == 8'd0) begin
                        state_d = ST_MENU;
                        opt_d   = OPT_1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opt_q   <= OPT_1;
            p1_q    <= HP_INIT;
            p2_q    <= HP_INIT;
            dmg_q   <= 8'd0;
            cnt_q   <= 8'd0;
            win_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opt_q   <= opt_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            dmg_q   <= dmg_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign fight_state  = state_q;
    assign option_state = opt_q;
    assign p1_cur_hp    = p1_q;
    assign p2_cur_hp    = p2_q;
    assign winner       = win_q;
    assign fight_done   = done_q;

endmodule

// File: tb/tb_fight_controller.sv
module tb_fight_controller;

    localparam logic [7:0] SEED = 8'hA5;

    localparam logic [6:0] K_TICK  = 7'b0000001;
    localparam logic [6:0] K_RIGHT = 7'b0000010;
    localparam logic [6:0] K_LEFT  = 7'b0000100;
    localparam logic [6:0] K_DOWN  = 7'b0001000;
    localparam logic [6:0] K_UP    = 7'b0010000;
    localparam logic [6:0] K_ENTER = 7'b0100000;
    localparam logic [6:0] K_START = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, start, key_up, key_down, key_left, key_right, key_enter;
    logic [5:0] fight_state;
    logic [3:0] option_state;
    logic [7:0] p1_cur_hp, p2_cur_hp;
    logic [1:0] winner;
    logic       fight_done;

    int n_chk = 0;
    int n_err = 0;
    int p1m, p2m, win_m;
    bit ended;
    logic [7:0] lfsr_m, lfsr_prev;

    fight_controller #(
        .HP_MAX    (200),
        .ANIM_TICKS(4),
        .LFSR_SEED (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .key_up      (key_up),
        .key_down    (key_down),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_enter   (key_enter),
        .fight_state (fight_state),
        .option_state(option_state),
        .p1_cur_hp   (p1_cur_hp),
        .p2_cur_hp   (p2_cur_hp),
        .winner      (winner),
        .fight_done  (fight_done)
    );

    always #5 clk = ~clk;

    // Reference LFSR; lfsr_prev holds the value the DUT saw before the last edge.
    always @(posedge clk) begin
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        lfsr_prev <= lfsr_m;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] v);
        {start, key_enter, key_up, key_down, key_left, key_right, tick} = v;
    endtask

    task automatic press(input logic [6:0] v);
        set_in(v);
        step();
        set_in(7'd0);
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One full exchange starting in MENU: P1 picks opt, CPU answers.
    task automatic do_round(input int opt, input bit poke, output bit fin);
        int anim, drain, guard, cd, exp_d;
        logic [5:0] sb;
        bit t;
        fin = 0;
        press(K_ENTER);
        check("menu_enter", fight_state, 2);
        check("opt_reset", option_state, 1);
        if (opt == 2 || opt == 4) press(K_RIGHT);
        if (opt >= 3) press(K_DOWN);
        check("opt_sel", option_state, opt);
        press(K_ENTER | K_TICK);   // tick on the entry edge must not count
        check("enter_anim_p1", fight_state, 3);

        anim = 0; drain = 0; guard = 0; t = 0;
        while ((fight_state == 3 || fight_state == 6) && guard < 1000) begin
            sb = fight_state;
            set_in(t ? K_TICK : 7'd0);
            step();
            set_in(7'd0);
            if (t && sb == 3) anim++;
            if (t && sb == 6) drain++;
            t = ~t;
            guard++;
        end
        exp_d = min2(opt * 10, p2m);
        p2m   = p2m - exp_d;
        check("anim_p1_ticks", anim, 4);
        check("drain_p2_ticks", drain, exp_d);
        check("p2_hp", p2_cur_hp, p2m);
        if (p2m == 0) begin
            win_m = 1;
            check("state_done_p1win", fight_state, 7);
            check("winner_p1", winner, 1);
            check("done_p1win", fight_done, 1);
            fin = 1;
            return;
        end
        check("enter_anim_p2", fight_state, 4);
        cd = (int'(lfsr_prev[1:0]) + 1) * 10;

        anim = 0; drain = 0; guard = 0; t = 0;
        while ((fight_state == 4 || fight_state == 5) && guard < 1000) begin
            sb = fight_state;
            set_in((t ? K_TICK : 7'd0) |
                   ((poke && sb == 4) ? (K_RIGHT | K_UP | K_ENTER | K_START) : 7'd0));
            step();
            set_in(7'd0);
            if (poke && sb == 4 && fight_state == 4) check("opt_hold_anim_p2", option_state, opt);
            if (t && sb == 4) anim++;
            if (t && sb == 5) drain++;
            t = ~t;
            guard++;
        end
        exp_d = min2(cd, p1m);
        p1m   = p1m - exp_d;
        check("anim_p2_ticks", anim, 4);
        check("drain_p1_ticks", drain, exp_d);
        check("p1_hp", p1_cur_hp, p1m);
        if (p1m == 0) begin
            win_m = 2;
            check("state_done_p2win", fight_state, 7);
            check("winner_p2", winner, 2);
            fin = 1;
        end else begin
            check("back_to_menu", fight_state, 1);
            check("menu_opt", option_state, 1);
            check("p2_hp_kept", p2_cur_hp, p2m);
        end
    endtask

    initial begin
        int opts[5] = '{4, 4, 4, 3, 4};
        logic [3:0] opt_saved;

        rst = 1'b1;
        set_in(7'd0);
        repeat (3) step();
        check("rst_state", fight_state, 0);
        check("rst_opt", option_state, 1);
        check("rst_p1", p1_cur_hp, 200);
        check("rst_p2", p2_cur_hp, 200);
        check("rst_winner", winner, 0);
        check("rst_done", fight_done, 0);
        rst = 1'b0;

        press(K_ENTER);
        check("idle_ignores_enter", fight_state, 0);
        press(K_START);
        check("start_menu", fight_state, 1);
        check("start_opt", option_state, 1);
        check("start_p1", p1_cur_hp, 200);
        check("start_p2", p2_cur_hp, 200);

        press(K_RIGHT);
        check("menu_move", option_state, 2);
        press(K_ENTER);
        check("choosing", fight_state, 2);
        check("choosing_opt1", option_state, 1);
        press(K_RIGHT);
        check("nav_right", option_state, 2);
        press(K_DOWN);
        check("nav_down", option_state, 4);
        press(K_RIGHT);
        check("nav_wrap", option_state, 3);
        press(K_UP | K_LEFT);
        check("nav_up_over_left", option_state, 1);

        // Reset while animating aborts the fight.
        press(K_RIGHT);
        press(K_ENTER | K_TICK);
        press(K_TICK);
        step();
        press(K_TICK);
        check("mid_anim", fight_state, 3);
        rst = 1'b1;
        step();
        check("abort_state", fight_state, 0);
        check("abort_p1", p1_cur_hp, 200);
        check("abort_p2", p2_cur_hp, 200);
        check("abort_opt", option_state, 1);
        rst = 1'b0;

        press(K_START);
        p1m = 200; p2m = 200; win_m = 0;
        do_round(2, 0, ended);
        foreach (opts[i]) begin
            if (!ended) do_round(opts[i], 0, ended);
        end
        check("fight_ended", ended, 1);

        // DONE holds its outputs against ticks and keys.
        opt_saved = option_state;
        repeat (6) begin
            press(K_TICK | K_RIGHT | K_ENTER | K_UP);
            check("done_hold_state", fight_state, 7);
            check("done_hold_p1", p1_cur_hp, p1m);
            check("done_hold_p2", p2_cur_hp, p2m);
            check("done_hold_winner", winner, win_m);
            check("done_hold_flag", fight_done, 1);
            check("done_hold_opt", option_state, opt_saved);
        end

        press(K_START);
        check("restart_state", fight_state, 1);
        check("restart_p1", p1_cur_hp, 200);
        check("restart_p2", p2_cur_hp, 200);
        check("restart_winner", winner, 0);
        check("restart_done", fight_done, 0);
        check("restart_opt", option_state, 1);
        p1m = 200; p2m = 200;
        do_round(3, 1, ended);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
